calc_entry_fsm: RTL and testbench
=================================

Name: calc_entry_fsm

Overview:
- Parametrised, fully synchronous successor to the keypad calculator entry FSM.
- Collects operand A, an operator and operand B from single-cycle keypad strobes, with up to DIGITS BCD digits per operand, backspace support and result chaining.
- Hands the operands to the external arithmetic/BCD unit over a req/ack handshake with a timeout.
- Drives a DISP-digit BCD display bus consumed by the seven-segment driver.

Parameters:
DIGITS, 2, maximum BCD digits per operand (1..DISP)
DISP, 4, number of display digits (>= DIGITS)
TIMEOUT, 255, clk cycles to wait for calc_ack before entering ERROR (>= 1)

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  reset, asynchronous, active-high
key_valid  input  1  one-cycle strobe; key_code valid this cycle
key_code  input  8  keycode: 8'h00-8'h09 digit, 8'hF0 add, 8'hF1 sub, 8'hF2 mul, 8'hF3 div, 8'hFA equals, 8'hFB backspace, 8'hFC clear; all others ignored
a_bcd  output  4*DIGITS  operand A, BCD, right-aligned, unused digits 0
b_bcd  output  4*DIGITS  operand B, same format
op  output  2  operator: 0 add, 1 sub, 2 mul, 3 div
calc_req  output  1  request to arithmetic unit
calc_ack  input  1  one-cycle completion strobe from arithmetic unit
result_bcd  input  4*DISP  result, BCD, valid when calc_ack=1
calc_err  input  1  arithmetic error (div by 0, overflow, negative), valid with calc_ack
display  output  4*DISP  nibble i = display digit i, 4'hF = blank, 4'hE = 'E'
state_o  output  3  encoded state: 0 A_ENTRY, 1 B_ENTRY, 2 CALC, 3 SHOW, 4 ERROR

Behaviour:
- Reset: state A_ENTRY; a_bcd, b_bcd, op, and the digit counters na/nb all 0; calc_req 0; display all 4'hF; timeout counter 0.
- Keys are acted on only when key_valid=1. Effects are visible on outputs the cycle after the strobe.
- Clear key: from any state, on the next cycle go to A_ENTRY with the reset values. It aborts CALC immediately and drops calc_req. A calc_ack arriving in the same cycle as clear is discarded.
- A_ENTRY:
  - digit key with na<DIGITS: a_bcd <= {a_bcd, d} (shift left one nibble), na++. Digits beyond DIGITS are ignored.
  - backspace with na>0: shift right one nibble, na--.
  - operator key with na>0: latch op, go to B_ENTRY. With na=0 it is ignored.
  - equals is ignored.
- B_ENTRY:
  - digit and backspace keys act on b_bcd/nb, same rules as A.
  - operator key with nb=0 replaces op; with nb>0 it is ignored.
  - backspace with nb=0 returns to A_ENTRY, keeping A.
  - equals with nb>0: go to CALC. With nb=0 it is ignored.
- CALC:
  - calc_req=1 from the first CALC cycle until the cycle after calc_ack. a_bcd, b_bcd and op are held stable throughout.
  - calc_ack with calc_err=0: latch result_bcd, go to SHOW.
  - calc_ack with calc_err=1: go to ERROR.
  - Counter counts cycles in CALC. If it reaches TIMEOUT without ack, go to ERROR and drop calc_req.
  - All keys except clear are ignored in CALC.
- SHOW:
  - digit key: clear A and B, load the digit as A's first digit (na=1), go to A_ENTRY.
  - operator key: if result nibbles [DISP-1:DIGITS] are all 0, set a_bcd = result low DIGITS nibbles, na = DIGITS, latch op, clear B, go to B_ENTRY. Otherwise ignore.
  - equals: re-issue the calculation with the current result as A and the same B and op, under the same fit rule. Otherwise ignore.
  - backspace is ignored.
- ERROR: only the clear key has an effect; all others are ignored.
- Display:
  - A_ENTRY shows A; B_ENTRY and CALC show B. Only the last na/nb digits are shown, right-aligned, with leading positions 4'hF. With zero digits entered, digit 0 shows 0 and the rest are blank.
  - SHOW shows the latched result unchanged.
  - ERROR shows every nibble as 4'hE.
- Simultaneous events:
  - key_valid and calc_ack in the same CALC cycle: the ack is processed and the key is dropped, unless the key is clear.
  - calc_ack outside CALC is ignored.

Test Plan:
- Reset, then keys 1,2,F0,3,4,FA; ack with result 16'h0046 after 5 cycles -> display 0046, state SHOW, a_bcd=8'h12, b_bcd=8'h34, op=0, calc_req high for exactly 6 cycles.
- Keys 9,8,7 (DIGITS=2) then backspace -> a_bcd=8'h09, na=1, display FFF9; next key F1 -> state B_ENTRY, op=1.
- Keys 5,F2,F3,2,FA -> op=3 (operator replaced) at calc_req; ack with calc_err=1 -> display EEEE; key 4 ignored; FC -> A_ENTRY, display FFF0.
- Enter 1,F0,1,FA, never ack -> calc_req drops and ERROR is entered TIMEOUT cycles after CALC entry; with TIMEOUT=8, ERROR on cycle 8.
- From SHOW with result 0099, key F0 -> a_bcd=8'h99, B_ENTRY. From SHOW with result 0123, F0 ignored and state stays SHOW.
- FC during CALC -> calc_req low next cycle; a simultaneous calc_ack is discarded; rst asserted mid-entry -> all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/calc_entry_fsm.sv
// Keypad calculator entry FSM: collects A, operator and B as BCD digits,
// hands them to the arithmetic unit over req/ack and drives the BCD display.
module calc_entry_fsm #(
    parameter int unsigned DIGITS  = 2,
    parameter int unsigned DISP    = 4,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  key_valid,
    input  logic [7:0]            key_code,
    output logic [4*DIGITS-1:0]   a_bcd,
    output logic [4*DIGITS-1:0]   b_bcd,
    output logic [1:0]            op,
    output logic                  calc_req,
    input  logic                  calc_ack,
    input  logic [4*DISP-1:0]     result_bcd,
    input  logic                  calc_err,
    output logic [4*DISP-1:0]     display,
    output logic [2:0]            state_o
);

    localparam int unsigned AW = 4 * DIGITS;
    localparam int unsigned DW = 4 * DISP;
    localparam int unsigned NW = $clog2(DIGITS + 1);
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_A    = 3'd0,
        S_B    = 3'd1,
        S_CALC = 3'd2,
        S_SHOW = 3'd3,
        S_ERR  = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   a_q, a_d, b_q, b_d;
    logic [NW-1:0]   na_q, na_d, nb_q, nb_d;
    logic [1:0]      op_q, op_d;
    logic            req_q, req_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic [DW-1:0]   res_q, res_d;
    logic [DW-1:0]   disp_q, disp_d;

    logic            is_digit, is_op, is_eq, is_bs, is_clr;
    logic [3:0]      digit;
    logic            res_fits;

    // Key decode
    always_comb begin
        is_digit = key_valid && (key_code <= 8'h09);
        is_op    = key_valid && (key_code[7:2] == 6'b111100);
        is_eq    = key_valid && (key_code == 8'hFA);
        is_bs    = key_valid && (key_code == 8'hFB);
        is_clr   = key_valid && (key_code == 8'hFC);
        digit    = key_code[3:0];
        res_fits = ((res_q >> AW) == '0);
    end

    // State register and datapath flops
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_A;
            a_q     <= '0;
            b_q     <= '0;
            na_q    <= '0;
            nb_q    <= '0;
            op_q    <= '0;
            req_q   <= 1'b0;
            tmo_q   <= '0;
            res_q   <= '0;
            disp_q  <= '1;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            na_q    <= na_d;
            nb_q    <= nb_d;
            op_q    <= op_d;
            req_q   <= req_d;
            tmo_q   <= tmo_d;
            res_q   <= res_d;
            disp_q  <= disp_d;
        end
    end

    // Next-state and operand update
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        na_d    = na_q;
        nb_d    = nb_q;
        op_d    = op_q;
        tmo_d   = '0;
        res_d   = res_q;

        if (is_clr) begin
            state_d = S_A;
            a_d     = '0;
            b_d     = '0;
            na_d    = '0;
            nb_d    = '0;
            op_d    = '0;
            res_d   = '0;
        end else begin
            case (state_q)
                S_A: begin
                    if (is_digit && (na_q < NW'(DIGITS))) begin
                        a_d  = AW'({a_q, digit});
                        na_d = na_q + NW'(1);
                    end else if (is_bs && (na_q != '0)) begin
                        a_d  = a_q >> 4;
                        na_d = na_q - NW'(1);
                    end else if (is_op && (na_q != '0)) begin
                        op_d    = key_code[1:0];
                        state_d = S_B;
                    end
                end
                S_B: begin
                    if (is_digit && (nb_q < NW'(DIGITS))) begin
                        b_d  = AW'({b_q, digit});
                        nb_d = nb_q + NW'(1);
                    end else if (is_bs) begin
                        if (nb_q != '0) begin
                            b_d  = b_q >> 4;
                            nb_d = nb_q - NW'(1);
                        end else begin
                            state_d = S_A;
                        end
                    end else if (is_op && (nb_q == '0)) begin
                        op_d = key_code[1:0];
                    end else if (is_eq && (nb_q != '0)) begin
                        state_d = S_CALC;
                    end
                end
                S_CALC: begin
                    // Ack wins over a same-cycle timeout and any non-clear key
                    if (calc_ack) begin
                        if (calc_err) begin
                            state_d = S_ERR;
                        end else begin
                            res_d   = result_bcd;
                            state_d = S_SHOW;
                        end
                    end else if (tmo_q == TW'(TIMEOUT - 1)) begin
                        state_d = S_ERR;
                    end else begin
                        tmo_d = tmo_q + TW'(1);
                    end
                end
                S_SHOW: begin
                    if (is_digit) begin
                        a_d     = AW'(digit);
                        na_d    = NW'(1);
                        b_d     = '0;
                        nb_d    = '0;
                        state_d = S_A;
                    end else if (is_op && res_fits) begin
                        a_d     = res_q[AW-1:0];
                        na_d    = NW'(DIGITS);
                        op_d    = key_code[1:0];
                        b_d     = '0;
                        nb_d    = '0;
                        state_d = S_B;
                    end else if (is_eq && res_fits) begin
                        a_d     = res_q[AW-1:0];
                        na_d    = NW'(DIGITS);
                        state_d = S_CALC;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Request and display follow the next state so they line up with it
    always_comb begin
        logic [DW-1:0] val_ext;
        logic [NW-1:0] n;
        req_d   = (state_d == S_CALC);
        disp_d  = '1;
        val_ext = (state_d == S_A) ? DW'(a_d) : DW'(b_d);
        n       = (state_d == S_A) ? na_d : nb_d;
        case (state_d)
            S_SHOW: disp_d = res_d;
            S_ERR:  disp_d = {DISP{4'hE}};
            default: begin
                for (int unsigned i = 0; i < DISP; i++) begin
                    if (i < 32'(n)) begin
                        disp_d[4*i +: 4] = val_ext[4*i +: 4];
                    end
                end
                if (n == '0) begin
                    disp_d[3:0] = 4'h0;
                end
            end
        endcase
    end

    assign a_bcd    = a_q;
    assign b_bcd    = b_q;
    assign op       = op_q;
    assign calc_req = req_q;
    assign display  = disp_q;
    assign state_o  = state_q;

endmodule

// File: tb/tb_calc_entry_fsm.sv
// Directed bench for calc_entry_fsm (DIGITS=2, DISP=4, TIMEOUT=8).
module tb_calc_entry_fsm;

    logic        clk;
    logic        rst;
    logic        key_valid;
    logic [7:0]  key_code;
    logic [7:0]  a_bcd;
    logic [7:0]  b_bcd;
    logic [1:0]  op;
    logic        calc_req;
    logic        calc_ack;
    logic [15:0] result_bcd;
    logic        calc_err;
    logic [15:0] display;
    logic [2:0]  state_o;

    int tests;
    int failed;

    calc_entry_fsm #(.DIGITS(2), .DISP(4), .TIMEOUT(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .key_valid  (key_valid),
        .key_code   (key_code),
        .a_bcd      (a_bcd),
        .b_bcd      (b_bcd),
        .op         (op),
        .calc_req   (calc_req),
        .calc_ack   (calc_ack),
        .result_bcd (result_bcd),
        .calc_err   (calc_err),
        .display    (display),
        .state_o    (state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One-cycle key strobe; called and returns at a negedge
    task automatic press(input logic [7:0] k);
        key_code  = k;
        key_valid = 1'b1;
        @(negedge clk);
        key_valid = 1'b0;
        key_code  = 8'h00;
    endtask

    task automatic ack(input logic [15:0] r, input logic e);
        calc_ack   = 1'b1;
        result_bcd = r;
        calc_err   = e;
        @(negedge clk);
        calc_ack   = 1'b0;
        calc_err   = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; key_valid = 1'b0; key_code = 8'h00;
        calc_ack = 1'b0; calc_err = 1'b0; result_bcd = 16'h0000;
        #12;
        tests++; if (state_o !== 3'd0) begin failed++; $display("FAIL reset_state got %0h exp 0", state_o); end
        tests++; if (a_bcd !== 8'h00 || b_bcd !== 8'h00 || op !== 2'd0) begin failed++; $display("FAIL reset_operands got a=%h b=%h op=%0d exp 0", a_bcd, b_bcd, op); end
        tests++; if (calc_req !== 1'b0) begin failed++; $display("FAIL reset_req got %b exp 0", calc_req); end
        tests++; if (display !== 16'hFFFF) begin failed++; $display("FAIL reset_display got %h exp ffff", display); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic_calc();
        int cnt;
        cnt = 0;
        press(8'h01); press(8'h02);
        tests++; if (display !== 16'hFF12) begin failed++; $display("FAIL a_display got %h exp ff12", display); end
        press(8'hF0); press(8'h03); press(8'h04);
        tests++; if (state_o !== 3'd1 || display !== 16'hFF34) begin failed++; $display("FAIL b_entry got st=%0d disp=%h exp 1 ff34", state_o, display); end
        press(8'hFA);
        repeat (5) begin
            if (calc_req) cnt++;
            @(negedge clk);
        end
        if (calc_req) cnt++;
        ack(16'h0046, 1'b0);
        repeat (3) begin
            if (calc_req) cnt++;
            @(negedge clk);
        end
        tests++; if (cnt !== 6) begin failed++; $display("FAIL req_cycles got %0d exp 6", cnt); end
        tests++; if (state_o !== 3'd3 || display !== 16'h0046) begin failed++; $display("FAIL show got st=%0d disp=%h exp 3 0046", state_o, display); end
        tests++; if (a_bcd !== 8'h12 || b_bcd !== 8'h34 || op !== 2'd0) begin failed++; $display("FAIL held_operands got a=%h b=%h op=%0d exp 12 34 0", a_bcd, b_bcd, op); end
    endtask

    task automatic test_backspace();
        press(8'h09); press(8'h08); press(8'h07);
        tests++; if (a_bcd !== 8'h98) begin failed++; $display("FAIL digit_limit got %h exp 98", a_bcd); end
        press(8'hFB);
        tests++; if (a_bcd !== 8'h09 || display !== 16'hFFF9 || state_o !== 3'd0) begin failed++; $display("FAIL backspace got a=%h disp=%h st=%0d exp 09 fff9 0", a_bcd, display, state_o); end
        press(8'hF1);
        tests++; if (state_o !== 3'd1 || op !== 2'd1 || display !== 16'hFFF0) begin failed++; $display("FAIL op_sub got st=%0d op=%0d disp=%h exp 1 1 fff0", state_o, op, display); end
        press(8'hFB);
        tests++; if (state_o !== 3'd0 || a_bcd !== 8'h09 || display !== 16'hFFF9) begin failed++; $display("FAIL bs_to_a got st=%0d a=%h disp=%h exp 0 09 fff9", state_o, a_bcd, display); end
    endtask

    task automatic test_error();
        press(8'hFC);
        press(8'h05); press(8'hF2); press(8'hF3); press(8'h02); press(8'hFA);
        tests++; if (state_o !== 3'd2 || op !== 2'd3 || calc_req !== 1'b1) begin failed++; $display("FAIL op_replace got st=%0d op=%0d req=%b exp 2 3 1", state_o, op, calc_req); end
        tests++; if (a_bcd !== 8'h05 || b_bcd !== 8'h02 || display !== 16'hFFF2) begin failed++; $display("FAIL calc_operands got a=%h b=%h disp=%h exp 05 02 fff2", a_bcd, b_bcd, display); end
        press(8'h04);
        tests++; if (state_o !== 3'd2 || b_bcd !== 8'h02) begin failed++; $display("FAIL calc_key_ignored got st=%0d b=%h exp 2 02", state_o, b_bcd); end
        ack(16'h0000, 1'b1);
        tests++; if (state_o !== 3'd4 || display !== 16'hEEEE || calc_req !== 1'b0) begin failed++; $display("FAIL err_state got st=%0d disp=%h req=%b exp 4 eeee 0", state_o, display, calc_req); end
        press(8'h04);
        tests++; if (state_o !== 3'd4 || display !== 16'hEEEE) begin failed++; $display("FAIL err_key_ignored got st=%0d disp=%h exp 4 eeee", state_o, display); end
        press(8'hFC);
        tests++; if (state_o !== 3'd0 || display !== 16'hFFF0 || a_bcd !== 8'h00) begin failed++; $display("FAIL err_clear got st=%0d disp=%h a=%h exp 0 fff0 00", state_o, display, a_bcd); end
    endtask

    task automatic test_timeout();
        int n;
        n = 0;
        press(8'h01); press(8'hF0); press(8'h01); press(8'hFA);
        while (state_o === 3'd2 && n < 40) begin
            n++;
            @(negedge clk);
        end
        tests++; if (n !== 8) begin failed++; $display("FAIL timeout_cycles got %0d exp 8", n); end
        tests++; if (state_o !== 3'd4 || calc_req !== 1'b0) begin failed++; $display("FAIL timeout_err got st=%0d req=%b exp 4 0", state_o, calc_req); end
        press(8'hFC);
    endtask

    task automatic test_chaining();
        press(8'h01); press(8'hF0); press(8'h01); press(8'hFA);
        ack(16'h0099, 1'b0);
        press(8'hFA);
        tests++; if (state_o !== 3'd2 || a_bcd !== 8'h99 || b_bcd !== 8'h01 || calc_req !== 1'b1) begin failed++; $display("FAIL eq_chain got st=%0d a=%h b=%h req=%b exp 2 99 01 1", state_o, a_bcd, b_bcd, calc_req); end
        ack(16'h0099, 1'b0);
        press(8'hF0);
        tests++; if (state_o !== 3'd1 || a_bcd !== 8'h99 || b_bcd !== 8'h00 || display !== 16'hFFF0) begin failed++; $display("FAIL op_chain got st=%0d a=%h b=%h disp=%h exp 1 99 00 fff0", state_o, a_bcd, b_bcd, display); end
        press(8'h01); press(8'hFA);
        ack(16'h0100, 1'b0);
        press(8'hF0);
        tests++; if (state_o !== 3'd3 || display !== 16'h0100) begin failed++; $display("FAIL op_nofit got st=%0d disp=%h exp 3 0100", state_o, display); end
        press(8'hFA);
        tests++; if (state_o !== 3'd3 || calc_req !== 1'b0) begin failed++; $display("FAIL eq_nofit got st=%0d req=%b exp 3 0", state_o, calc_req); end
        press(8'h07);
        tests++; if (state_o !== 3'd0 || a_bcd !== 8'h07 || b_bcd !== 8'h00 || display !== 16'hFFF7) begin failed++; $display("FAIL show_digit got st=%0d a=%h b=%h disp=%h exp 0 07 00 fff7", state_o, a_bcd, b_bcd, display); end
    endtask

    task automatic test_simultaneous();
        press(8'hFC);
        press(8'h02); press(8'hF0); press(8'h03); press(8'hFA);
        key_code = 8'h05; key_valid = 1'b1;
        ack(16'h0005, 1'b0);
        key_valid = 1'b0; key_code = 8'h00;
        tests++; if (state_o !== 3'd3 || display !== 16'h0005 || a_bcd !== 8'h02) begin failed++; $display("FAIL ack_over_key got st=%0d disp=%h a=%h exp 3 0005 02", state_o, display, a_bcd); end
        ack(16'h0077, 1'b0);
        tests++; if (state_o !== 3'd3 || display !== 16'h0005) begin failed++; $display("FAIL ack_outside got st=%0d disp=%h exp 3 0005", state_o, display); end
        press(8'hFC);
        press(8'h02); press(8'hF0); press(8'h03); press(8'hFA);
        key_code = 8'hFC; key_valid = 1'b1;
        ack(16'h0055, 1'b0);
        key_valid = 1'b0; key_code = 8'h00;
        tests++; if (state_o !== 3'd0 || calc_req !== 1'b0 || display !== 16'hFFF0 || a_bcd !== 8'h00) begin failed++; $display("FAIL clear_in_calc got st=%0d req=%b disp=%h a=%h exp 0 0 fff0 00", state_o, calc_req, display, a_bcd); end
    endtask

    task automatic test_async_reset();
        press(8'h03); press(8'hF2); press(8'h04);
        #2 rst = 1'b1;
        #1;
        tests++; if (state_o !== 3'd0 || a_bcd !== 8'h00 || b_bcd !== 8'h00 || op !== 2'd0) begin failed++; $display("FAIL async_rst_regs got st=%0d a=%h b=%h op=%0d exp 0 00 00 0", state_o, a_bcd, b_bcd, op); end
        tests++; if (display !== 16'hFFFF || calc_req !== 1'b0) begin failed++; $display("FAIL async_rst_out got disp=%h req=%b exp ffff 0", display, calc_req); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        tests  = 0;
        failed = 0;
        test_reset();
        test_basic_calc();
        test_backspace();
        test_error();
        test_timeout();
        test_chaining();
        test_simultaneous();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
